// File: rtl/cc_button_debounce.sv
// Input conditioner for the two-input gate stage: per-channel 2-flop
// synchroniser, debounce FSM with stability counter, and registered
// level / rise / fall outputs. Each channel runs independently.
module cc_button_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic             CC_BUTTON_DEBOUNCE_CLOCK_50,
    input  logic             CC_BUTTON_DEBOUNCE_RESET_InLow,
    input  logic [WIDTH-1:0] CC_BUTTON_DEBOUNCE_raw_In,
    output logic [WIDTH-1:0] CC_BUTTON_DEBOUNCE_level_Out,
    output logic [WIDTH-1:0] CC_BUTTON_DEBOUNCE_rise_Out,
    output logic [WIDTH-1:0] CC_BUTTON_DEBOUNCE_fall_Out
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    // Final count value: the level flips on the edge that sees this count
    // with the new polarity still present.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic                 meta_r;
        logic                 sync_r;
        state_t               state_r;
        state_t               state_s;
        logic [CNT_WIDTH-1:0] cnt_r;
        logic [CNT_WIDTH-1:0] cnt_s;
        logic                 level_r;
        logic                 level_s;
        logic                 rise_r;
        logic                 rise_s;
        logic                 fall_r;
        logic                 fall_s;

        // Two-flop synchroniser; the raw line is only ever observed via sync_r.
        always_ff @(posedge CC_BUTTON_DEBOUNCE_CLOCK_50 or negedge CC_BUTTON_DEBOUNCE_RESET_InLow) begin
            if (!CC_BUTTON_DEBOUNCE_RESET_InLow) begin
                meta_r <= 1'b0;
                sync_r <= 1'b0;
            end else begin
                meta_r <= CC_BUTTON_DEBOUNCE_raw_In[i];
                sync_r <= meta_r;
            end
        end

        // Debounce state, counter and output registers.
        always_ff @(posedge CC_BUTTON_DEBOUNCE_CLOCK_50 or negedge CC_BUTTON_DEBOUNCE_RESET_InLow) begin
            if (!CC_BUTTON_DEBOUNCE_RESET_InLow) begin
                state_r <= STABLE_LOW;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b0;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                level_r <= level_s;
                rise_r  <= rise_s;
                fall_r  <= fall_s;
            end
        end

        // Next-state logic: any opposite sample in a WAIT state discards the
        // partial count; pulses default low so they last exactly one cycle.
        always_comb begin
            state_s = state_r;
            cnt_s   = CNT_ZERO;
            level_s = level_r;
            rise_s  = 1'b0;
            fall_s  = 1'b0;
            case (state_r)
                STABLE_LOW: begin
                    if (sync_r) begin
                        state_s = WAIT_HIGH;
                    end else begin
                        state_s = STABLE_LOW;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_r) begin
                        state_s = STABLE_LOW;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = STABLE_HIGH;
                        level_s = 1'b1;
                        rise_s  = 1'b1;
                    end else begin
                        state_s = WAIT_HIGH;
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_r) begin
                        state_s = WAIT_LOW;
                    end else begin
                        state_s = STABLE_HIGH;
                    end
                end
                WAIT_LOW: begin
                    if (sync_r) begin
                        state_s = STABLE_HIGH;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = STABLE_LOW;
                        level_s = 1'b0;
                        fall_s  = 1'b1;
                    end else begin
                        state_s = WAIT_LOW;
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = STABLE_LOW;
                    level_s = 1'b0;
                end
            endcase
        end

        assign CC_BUTTON_DEBOUNCE_level_Out[i] = level_r;
        assign CC_BUTTON_DEBOUNCE_rise_Out[i]  = rise_r;
        assign CC_BUTTON_DEBOUNCE_fall_Out[i]  = fall_r;
    end

endmodule

// File: tb/tb_cc_button_debounce.sv
// Directed bench for cc_button_debounce with WIDTH=2, DEBOUNCE_CYCLES=4.
module tb_cc_button_debounce;
    localparam int WIDTH = 2;
    localparam int DEB   = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] raw;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cc_button_debounce #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH(CW)
    ) dut (
        .CC_BUTTON_DEBOUNCE_CLOCK_50(clk),
        .CC_BUTTON_DEBOUNCE_RESET_InLow(rst_n),
        .CC_BUTTON_DEBOUNCE_raw_In(raw),
        .CC_BUTTON_DEBOUNCE_level_Out(level),
        .CC_BUTTON_DEBOUNCE_rise_Out(rise),
        .CC_BUTTON_DEBOUNCE_fall_Out(fall)
    );

    task automatic check(input string name, input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
        checks++;
        if ({level, rise, fall} !== {l, r, f}) begin
            failures++;
            $display("FAIL %s: level/rise/fall got %b/%b/%b required %b/%b/%b",
                     name, level, rise, fall, l, r, f);
        end
    endtask

    task automatic add(input string name, input logic [1:0] r, input logic [1:0] l,
                       input logic [1:0] ri, input logic [1:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{r, l, ri, f, name});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each record: drive raw, take one clock edge, compare outputs.
        // Level changes on the 7th record (edge k+6) of a held change.
        add("t2_wait",   2'b01, 2'b00, 2'b00, 2'b00, 6);
        add("t2_rise",   2'b01, 2'b01, 2'b01, 2'b00, 1);
        add("t2_hold",   2'b01, 2'b01, 2'b00, 2'b00, 3);
        add("rel0_wait", 2'b00, 2'b01, 2'b00, 2'b00, 6);
        add("rel0_fall", 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add("rel0_hold", 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add("t3_bounce", 2'b01, 2'b00, 2'b00, 2'b00, 3);
        add("t3_gap",    2'b00, 2'b00, 2'b00, 2'b00, 6);
        add("t3_wait",   2'b01, 2'b00, 2'b00, 2'b00, 6);
        add("t3_rise",   2'b01, 2'b01, 2'b01, 2'b00, 1);
        add("t3_hold",   2'b01, 2'b01, 2'b00, 2'b00, 3);
        add("rel0b_wait",2'b00, 2'b01, 2'b00, 2'b00, 6);
        add("rel0b_fall",2'b00, 2'b00, 2'b00, 2'b01, 1);
        add("rel0b_hold",2'b00, 2'b00, 2'b00, 2'b00, 3);
        add("t5_wait",   2'b11, 2'b00, 2'b00, 2'b00, 6);
        add("t5_rise",   2'b11, 2'b11, 2'b11, 2'b00, 1);
        add("t5_hold",   2'b11, 2'b11, 2'b00, 2'b00, 3);
        add("t4_wait",   2'b01, 2'b11, 2'b00, 2'b00, 6);
        add("t4_fall",   2'b01, 2'b01, 2'b00, 2'b10, 1);
        add("t4_hold",   2'b01, 2'b01, 2'b00, 2'b00, 3);

        // Test 1: reset held for 5 cycles, then 20 quiet cycles.
        rst_n = 1'b0;
        raw   = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_in_reset", 2'b00, 2'b00, 2'b00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_after_reset", 2'b00, 2'b00, 2'b00);
        end

        // Tests 2-5 from the vector table.
        foreach (vecs[j]) begin
            raw = vecs[j].raw;
            tick();
            check(vecs[j].name, vecs[j].level, vecs[j].rise, vecs[j].fall);
            if (vecs[j].name == "t5_rise") begin
                checks++;
                if ((level[0] & level[1]) !== 1'b1) begin
                    failures++;
                    $display("FAIL t5_gate: gate got %b required 1", level[0] & level[1]);
                end
            end
        end

        // Test 6: reset while channel 1 is in WAIT_HIGH with cnt=2.
        raw = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_pre", 2'b01, 2'b00, 2'b00);
        end
        rst_n = 1'b0;
        #1;
        check("t6_async", 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_in_reset", 2'b00, 2'b00, 2'b00);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e < 7) begin
                check("t6_wait", 2'b00, 2'b00, 2'b00);
            end else if (e == 7) begin
                check("t6_rise", 2'b11, 2'b11, 2'b00);
            end else begin
                check("t6_hold", 2'b11, 2'b00, 2'b00);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
